mac_seq: RTL
============

Name: mac_seq

Overview:
- Dot-product sequencer for the conv datapath.
- Owns one registered fixed-point multiplier stage (Q(IW).(FW), product arithmetic-shifted right by FW and truncated to IW+FW bits) and an accumulator.
- Accepts a job (length and bias), streams length fmap/weight pairs through the multiplier under valid/ready, then presents the accumulated sum on a valid/ready output.
- Sits between the line-buffer/weight fetch and the activation/write-back stage.

Parameters:
IW, 24, integer bits of fixed-point operands and result
FW, 8, fractional bits; product is shifted right arithmetically by FW
CW, 8, width of the job length field (max length 2^CW-1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse, honoured only in IDLE
cfg_len  in  CW  number of pairs in the job, sampled with start
cfg_bias  in  IW+FW  signed initial accumulator value, sampled with start
in_valid  in  1  fmap/weight pair valid
in_ready  out  1  pair accepted when in_valid & in_ready
in_fmap  in  IW+FW  signed feature value
in_wht  in  IW+FW  signed weight value
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  IW+FW  signed accumulated result
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, count=0, acc=0, product register=0, product-valid=0. Outputs in_ready=0, out_valid=0, out_data=0, busy=0.
- Reset mid-job aborts the job. In-flight products are discarded and no result is emitted.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - On start with cfg_len!=0: latch len, acc<=cfg_bias, count<=0, go to RUN.
  - On start with cfg_len==0: acc<=cfg_bias, go to OUT. Result = bias one cycle after start.
- RUN:
  - in_ready=1 (combinational decode of state only; no dependency on in_valid).
  - Each accept loads the multiplier: prod_reg <= in_fmap*in_wht (full 2*(IW+FW) signed). Product-valid is set the following cycle. count++.
  - Accept with count==len-1 moves to DRAIN. in_ready is 0 from the next cycle.
- Multiplier/accumulate:
  - A registered product with its valid bit set adds into acc in that cycle: acc <= acc + (prod_reg >>> FW)[IW+FW-1:0].
  - Shift floors toward -inf; upper bits are discarded.
  - Accumulation is two's-complement wrap-around, no saturation.
  - Accumulate and a new accept may occur in the same cycle (full throughput, one pair per cycle).
- DRAIN: one cycle in which the final product accumulates, then OUT.
- OUT:
  - out_valid=1, out_data=acc, both held stable until out_ready.
  - On out_valid & out_ready, go to IDLE. out_valid drops the next cycle.
- Latency: last pair accepted in cycle T gives out_valid in T+2. A job of N pairs with continuous in_valid, started in cycle S, gives out_valid at S+N+2.
- start outside IDLE is ignored. Inputs are don't-care when in_ready=0.
- in_valid gaps stall count only. acc is unaffected except for pending product accumulation.
- out_data is 0 outside OUT.

Test Plan:
- Basic dot: bias=0, len=9, nine pairs fmap=256 (1.0), wht=256 (1.0), in_valid continuous -> out_data=2304, out_valid exactly 11 cycles after start, busy high start+1 through handshake.
- Sign/truncation: len=3, bias=0, pairs (512,768),(-384,128),(-1,1) -> products 1536, -192, -1 -> out_data=1343.
- Backpressure: len=4, in_valid toggling 1,0,0,1,1,0,1; hold out_ready=0 for 5 cycles in OUT -> out_data stable, equals sum, in_ready=0 after 4th accept, returns to IDLE only on out_ready.
- Edge cases: len=0, bias=-1000 -> out_valid one cycle after start with out_data=-1000. Then start asserted during RUN of a new job -> ignored, count unchanged.
- Wrap: bias=0x7FFFFF00, len=1, pair (256,256) -> out_data=0x80000000 (wrap, no saturation).
- Reset mid-operation: assert rst_n=0 after 5 of 9 accepts -> all outputs 0 immediately. After release, state is IDLE and no out_valid occurs until a new start; the new job result is unaffected by the aborted one.

Source files
------------

// File: rtl/mac_seq.sv
// ---------------------------------------------------------------------------
// mac_seq : dot-product sequencer for the conv datapath.
//
// Takes a job (length + bias), streams <length> fmap/weight pairs through a
// registered fixed-point multiplier and accumulates them, then presents the
// accumulated sum on a valid/ready output. Operands and result are signed
// Q(IW).(FW); each product is arithmetic-shifted right by FW and truncated
// to IW+FW bits before it is added, with two's-complement wrap-around.
//
// Handshake semantics (both the pair input and the result output): a
// transfer happens on a rising clock edge where valid and ready are both
// high. in_ready decodes the state only and never looks at in_valid.
// out_valid/out_data stay stable from the first cycle of OUT until the
// transfer cycle and do not depend on out_ready.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   start      job start pulse, honoured only in IDLE
//   cfg_len    number of pairs in the job, sampled with start
//   cfg_bias   signed initial accumulator value, sampled with start
//   in_valid   fmap/weight pair valid
//   in_ready   pair accepted when in_valid & in_ready (high in RUN)
//   in_fmap    signed feature value
//   in_wht     signed weight value
//   out_valid  result valid (high in OUT)
//   out_ready  downstream accepts result
//   out_data   signed accumulated result, 0 outside OUT
//   busy       high whenever the sequencer is not IDLE
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 OUT)
//   dbg_count  number of pairs accepted so far in the current job
// ---------------------------------------------------------------------------
module mac_seq #(
    parameter int IW = 24,
    parameter int FW = 8,
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CW-1:0]    cfg_len,
    input  logic [IW+FW-1:0] cfg_bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW+FW-1:0] in_fmap,
    input  logic [IW+FW-1:0] in_wht,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW+FW-1:0] out_data,
    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic [CW-1:0]    dbg_count
);

    localparam int W = IW + FW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [CW-1:0]    r_len;
    logic [CW-1:0]    r_count;
    logic [W-1:0]     r_acc;
    logic [2*W-1:0]   r_prod;
    logic             r_pvld;

    logic             w_accept;
    logic             w_last;
    logic             w_load_bias;
    logic [2*W-1:0]   w_fmap_x;
    logic [2*W-1:0]   w_wht_x;
    logic [2*W-1:0]   w_mul;
    logic [W-1:0]     w_addend;
    logic             w_unused_prod;

    // ---------------------------------------------------------------------
    // Multiplier. Both operands are sign-extended to the full product width,
    // so the low 2*W bits of the unsigned product equal the signed product.
    // ---------------------------------------------------------------------
    assign w_fmap_x = {{W{in_fmap[W-1]}}, in_fmap};
    assign w_wht_x  = {{W{in_wht[W-1]}},  in_wht};
    assign w_mul    = w_fmap_x * w_wht_x;

    // (prod >>> FW) truncated to W bits is exactly bits [FW +: W] of the
    // product: the arithmetic shift only affects bits that are discarded,
    // and dropping the low FW bits is a floor toward -inf.
    assign w_addend = r_prod[FW +: W];

    // Product bits outside the kept window are architecturally unused.
    assign w_unused_prod = ^{r_prod[2*W-1:FW+W], r_prod[FW-1:0]};

    assign w_accept    = in_valid & in_ready;
    assign w_last      = (r_count == (r_len - CW'(1)));
    assign w_load_bias = (r_state == ST_IDLE) && start;

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state and output decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    // A zero-length job has nothing to stream; the bias is
                    // the result and is presented on the next cycle.
                    w_next = (cfg_len == '0) ? ST_OUT : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final product is added into the accumulator here.
                w_next = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                out_data  = r_acc;
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Job length and accepted-pair counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len   <= '0;
            r_count <= '0;
        end else if (w_load_bias) begin
            r_len   <= cfg_len;
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Product register. r_pvld marks a product that still has to be added;
    // it is set only by an accept, so it is clear in IDLE and OUT and a
    // stale product can never leak into the next job.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_pvld <= 1'b0;
        end else begin
            r_pvld <= w_accept;
            if (w_accept) begin
                r_prod <= w_mul;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Accumulator. Adding the pending product and accepting the next pair
    // happen in the same cycle, giving one pair per cycle of throughput.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_load_bias) begin
            r_acc <= cfg_bias;
        end else if (r_pvld) begin
            r_acc <= r_acc + w_addend;
        end
    end

    assign dbg_state = r_state;
    assign dbg_count = r_count;

endmodule
